// File: rtl/mem_wb_stage_param.sv
// MEM stage with byte-addressable data memory, RV32I load/store sizing, wait-state stall
// handshake, access fault detection and the MEM/WB pipeline register.
module mem_wb_stage_param #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned RSRC_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_m,
  input  logic              reg_write_m,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic [RSRC_W-1:0] result_src_m,
  input  logic [2:0]        funct3_m,
  input  logic [XLEN-1:0]   alu_result_m,
  input  logic [XLEN-1:0]   write_data_m,
  input  logic [XLEN-1:0]   pc_plus4_m,
  input  logic [4:0]        rd_m,
  input  logic              flush_w,
  output logic              stall_m,
  output logic              valid_w,
  output logic              reg_write_w,
  output logic [RSRC_W-1:0] result_src_w,
  output logic [4:0]        rd_w,
  output logic [XLEN-1:0]   alu_result_w,
  output logic [XLEN-1:0]   read_data_w,
  output logic [XLEN-1:0]   pc_plus4_w,
  output logic              fault_w
);

  localparam int unsigned ABITS = $clog2(DEPTH);
  localparam int unsigned CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   mem_q [DEPTH];

  logic              access, illegal, misalign, fault, complete, mem_we;
  logic [ABITS-1:0]  widx;
  logic [1:0]        lane;
  logic [XLEN-1:0]   rword, load_val, wdata_rep;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic [3:0]        be;

  logic              valid_d, reg_write_d, fault_d;
  logic [RSRC_W-1:0] result_src_d;
  logic [4:0]        rd_d;
  logic [XLEN-1:0]   alu_result_d, read_data_d, pc_plus4_d;

  assign access = valid_m & (mem_read_m | mem_write_m);
  assign widx   = alu_result_m[ABITS+1:2];
  assign lane   = alu_result_m[1:0];

  // Illegal size encodings and misalignment both raise a fault on an access
  always_comb begin
    illegal  = (funct3_m == 3'b011) | (funct3_m == 3'b110) | (funct3_m == 3'b111);
    misalign = 1'b0;
    case (funct3_m[1:0])
      2'b01:   misalign = lane[0];
      2'b10:   misalign = (lane != 2'b00);
      default: misalign = 1'b0;
    endcase
  end

  assign fault = access & (illegal | misalign);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (access && !flush_w && (WAIT_STATES != 0)) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(WAIT_STATES - 1);
        end
      end
      S_WAIT: begin
        if (flush_w || (cnt_q == '0)) state_d = S_IDLE;
        else                          cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall covers the first WAIT_STATES cycles of an access; forced low while in reset
  always_comb begin
    stall_m = 1'b0;
    case (state_q)
      S_IDLE:  stall_m = access & ~flush_w & (WAIT_STATES != 0);
      S_WAIT:  stall_m = (cnt_q != '0);
      default: stall_m = 1'b0;
    endcase
    if (rst) stall_m = 1'b0;
  end

  assign complete = access & ~stall_m & ~flush_w & ~rst;
  assign mem_we   = complete & mem_write_m & ~fault;

  always_comb begin
    case (funct3_m[1:0])
      2'b00: begin
        wdata_rep = {4{write_data_m[7:0]}};
        be        = 4'b0001 << lane;
      end
      2'b01: begin
        wdata_rep = {2{write_data_m[15:0]}};
        be        = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_rep = write_data_m;
        be        = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][i*8 +: 8] <= wdata_rep[i*8 +: 8];
      end
    end
  end

  assign rword = mem_q[widx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    case (funct3_m)
      3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_val = {24'd0, rbyte};
      3'b101:  load_val = {16'd0, rhalf};
      default: load_val = rword;
    endcase
  end

  // MEM/WB next value: bubble while stalled or flushed
  always_comb begin
    valid_d      = valid_m;
    reg_write_d  = valid_m & reg_write_m & ~fault;
    fault_d      = fault;
    result_src_d = result_src_m;
    rd_d         = rd_m;
    alu_result_d = alu_result_m;
    pc_plus4_d   = pc_plus4_m;
    read_data_d  = (access & mem_read_m & ~fault) ? load_val : '0;
    if (flush_w || stall_m) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      fault_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      fault_w      <= 1'b0;
      result_src_w <= '0;
      rd_w         <= '0;
      alu_result_w <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
    end else begin
      valid_w      <= valid_d;
      reg_write_w  <= reg_write_d;
      fault_w      <= fault_d;
      result_src_w <= result_src_d;
      rd_w         <= rd_d;
      alu_result_w <= alu_result_d;
      read_data_w  <= read_data_d;
      pc_plus4_w   <= pc_plus4_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage_param.sv
// Scoreboard bench: a zero-wait instance and a two-wait-state instance, directed vectors,
// expected WB results queued at issue and popped by per-instance monitors.
module tb_mem_wb_stage_param;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [2:0]  rsrc;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        flush;
  } in_t;

  typedef struct packed {
    logic [2:0]  rsrc;
    logic [4:0]  rd;
    logic        rw;
    logic        fault;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  in_t  a, b;

  logic        o0_stall, o0_valid, o0_rw, o0_fault;
  logic [2:0]  o0_rsrc;
  logic [4:0]  o0_rd;
  logic [31:0] o0_alu, o0_rdata, o0_pc4;
  logic        o1_stall, o1_valid, o1_rw, o1_fault;
  logic [2:0]  o1_rsrc;
  logic [4:0]  o1_rd;
  logic [31:0] o1_alu, o1_rdata, o1_pc4;

  int   vectors = 0;
  int   miscompares = 0;
  bit   stall0_seen = 1'b0;
  exp_t q0[$], q1[$];
  exp_t act0, exp0, act1, exp1;
  logic [7:0] seq;

  always #5 clk = ~clk;

  mem_wb_stage_param #(.XLEN(32), .DEPTH(1024), .WAIT_STATES(0), .RSRC_W(3)) dut0 (
    .clk(clk), .rst(rst), .valid_m(a.valid), .reg_write_m(a.rw), .mem_read_m(a.mr),
    .mem_write_m(a.mw), .result_src_m(a.rsrc), .funct3_m(a.f3), .alu_result_m(a.alu),
    .write_data_m(a.wd), .pc_plus4_m(a.pc4), .rd_m(a.rd), .flush_w(a.flush),
    .stall_m(o0_stall), .valid_w(o0_valid), .reg_write_w(o0_rw), .result_src_w(o0_rsrc),
    .rd_w(o0_rd), .alu_result_w(o0_alu), .read_data_w(o0_rdata), .pc_plus4_w(o0_pc4),
    .fault_w(o0_fault)
  );

  mem_wb_stage_param #(.XLEN(32), .DEPTH(1024), .WAIT_STATES(2), .RSRC_W(3)) dut1 (
    .clk(clk), .rst(rst), .valid_m(b.valid), .reg_write_m(b.rw), .mem_read_m(b.mr),
    .mem_write_m(b.mw), .result_src_m(b.rsrc), .funct3_m(b.f3), .alu_result_m(b.alu),
    .write_data_m(b.wd), .pc_plus4_m(b.pc4), .rd_m(b.rd), .flush_w(b.flush),
    .stall_m(o1_stall), .valid_w(o1_valid), .reg_write_w(o1_rw), .result_src_w(o1_rsrc),
    .rd_w(o1_rd), .alu_result_w(o1_alu), .read_data_w(o1_rdata), .pc_plus4_w(o1_pc4),
    .fault_w(o1_fault)
  );

  function automatic in_t mk(bit rw, bit mr, bit mw, logic [2:0] f3, logic [31:0] alu,
                             logic [31:0] wd, logic [4:0] rd);
    in_t v;
    v       = '0;
    v.valid = 1'b1;
    v.rw    = rw;
    v.mr    = mr;
    v.mw    = mw;
    v.rsrc  = mr ? 3'd1 : 3'd0;
    v.f3    = f3;
    v.alu   = alu;
    v.wd    = wd;
    v.pc4   = 32'h8000_0000 | {27'd0, rd};
    v.rd    = rd;
    return v;
  endfunction

  function automatic exp_t ex(in_t v, logic [31:0] rdata, bit fault);
    exp_t e;
    e.rsrc  = v.rsrc;
    e.rd    = v.rd;
    e.rw    = v.rw & ~fault;
    e.fault = fault;
    e.alu   = v.alu;
    e.rdata = rdata;
    e.pc4   = v.pc4;
    return e;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic issue0(in_t v, logic [31:0] rdata, bit fault, bit push);
    a = v;
    if (push) q0.push_back(ex(v, rdata, fault));
    @(posedge clk);
    #1;
    a.valid = 1'b0;
    a.flush = 1'b0;
  endtask

  task automatic issue1(in_t v, logic [31:0] rdata, bit fault, bit push,
                        output logic [7:0] sq);
    bit st;
    bit done;
    b    = v;
    sq   = '0;
    done = 1'b0;
    if (push) q1.push_back(ex(v, rdata, fault));
    for (int n = 0; n < 16 && !done; n++) begin
      #1;
      st = o1_stall;
      sq = {sq[6:0], st};
      @(posedge clk);
      #1;
      if (!st) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL issue1_timeout: stall_m still %b, required 0 within 16 cycles", o1_stall);
    end
    b.valid = 1'b0;
  endtask

  // WB monitors: every valid WB output must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && o0_valid === 1'b1) begin
      act0 = {o0_rsrc, o0_rd, o0_rw, o0_fault, o0_alu, o0_rdata, o0_pc4};
      vectors++;
      if (q0.size() == 0) begin
        miscompares++;
        $display("FAIL wb0_unexpected: got %h required no valid output", act0);
      end else begin
        exp0 = q0.pop_front();
        if (act0 !== exp0) begin
          miscompares++;
          $display("FAIL wb0 rd=%0d: got %h required %h", exp0.rd, act0, exp0);
        end
      end
    end
    if (!rst && o0_stall === 1'b1) stall0_seen = 1'b1;
  end

  always @(negedge clk) begin
    if (!rst && o1_valid === 1'b1) begin
      act1 = {o1_rsrc, o1_rd, o1_rw, o1_fault, o1_alu, o1_rdata, o1_pc4};
      vectors++;
      if (q1.size() == 0) begin
        miscompares++;
        $display("FAIL wb1_unexpected: got %h required no valid output", act1);
      end else begin
        exp1 = q1.pop_front();
        if (act1 !== exp1) begin
          miscompares++;
          $display("FAIL wb1 rd=%0d: got %h required %h", exp1.rd, act1, exp1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    in_t v;
    a = '0;
    b = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset0", 128'({o0_stall, o0_valid, o0_rw, o0_fault, o0_rsrc, o0_rd, o0_alu, o0_rdata, o0_pc4}), 128'(0));
    chk("reset1", 128'({o1_stall, o1_valid, o1_rw, o1_fault, o1_rsrc, o1_rd, o1_alu, o1_rdata, o1_pc4}), 128'(0));
    rst = 1'b0;

    // Zero-wait instance: sizes, sign extension, faults, aliasing, flush
    v = mk(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);   issue0(v, 32'h0, 0, 1);
    v = mk(1, 1, 0, 3'b010, 32'h10, 32'h0, 5'd5);          issue0(v, 32'hDEADBEEF, 0, 1);
    v = mk(0, 0, 1, 3'b000, 32'h13, 32'h12345680, 5'd0);   issue0(v, 32'h0, 0, 1);
    v = mk(1, 1, 0, 3'b000, 32'h13, 32'h0, 5'd6);          issue0(v, 32'hFFFFFF80, 0, 1);
    v = mk(1, 1, 0, 3'b100, 32'h13, 32'h0, 5'd7);          issue0(v, 32'h00000080, 0, 1);
    v = mk(1, 1, 0, 3'b010, 32'h10, 32'h0, 5'd8);          issue0(v, 32'h80ADBEEF, 0, 1);
    v = mk(1, 1, 0, 3'b001, 32'h11, 32'h0, 5'd9);          issue0(v, 32'h0, 1, 1);
    v = mk(0, 0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 5'd0);   issue0(v, 32'h0, 0, 1);
    v = mk(0, 0, 1, 3'b010, 32'h22, 32'h11111111, 5'd0);   issue0(v, 32'h0, 1, 1);
    v = mk(1, 1, 0, 3'b010, 32'h20, 32'h0, 5'd10);         issue0(v, 32'hCAFEF00D, 0, 1);
    v = mk(1, 1, 0, 3'b011, 32'h20, 32'h0, 5'd11);         issue0(v, 32'h0, 1, 1);
    v = mk(0, 0, 1, 3'b001, 32'h22, 32'hA5A51234, 5'd0);   issue0(v, 32'h0, 0, 1);
    v = mk(1, 1, 0, 3'b001, 32'h22, 32'h0, 5'd12);         issue0(v, 32'h00001234, 0, 1);
    v = mk(1, 1, 0, 3'b101, 32'h20, 32'h0, 5'd13);         issue0(v, 32'h0000F00D, 0, 1);
    v = mk(1, 1, 0, 3'b001, 32'h20, 32'h0, 5'd14);         issue0(v, 32'hFFFFF00D, 0, 1);
    v = mk(1, 0, 0, 3'b011, 32'h55, 32'h0, 5'd15);         issue0(v, 32'h0, 0, 1);
    v = mk(0, 0, 1, 3'b010, 32'h1000, 32'h0BADC0DE, 5'd0); issue0(v, 32'h0, 0, 1);
    v = mk(0, 0, 1, 3'b010, 32'h0, 32'hFFFFFFFF, 5'd0);
    v.flush = 1'b1;                                        issue0(v, 32'h0, 0, 0);
    v = mk(1, 1, 0, 3'b010, 32'h0, 32'h0, 5'd16);          issue0(v, 32'h0BADC0DE, 0, 1);

    // Two-wait-state instance: stall pattern and completion timing
    v = mk(0, 0, 1, 3'b010, 32'h40, 32'h13572468, 5'd0);   issue1(v, 32'h0, 0, 1, seq);
    chk("sw_stall_seq", 128'(seq), 128'(8'h06));
    v = mk(1, 1, 0, 3'b010, 32'h40, 32'h0, 5'd3);          issue1(v, 32'h13572468, 0, 1, seq);
    chk("lw_stall_seq", 128'(seq), 128'(8'h06));
    chk("lw_valid_3rd_edge", 128'(o1_valid), 128'(1));

    // Flush during WAIT drops the store and releases the stall
    b = mk(0, 0, 1, 3'b010, 32'h40, 32'hFFFF0000, 5'd0);
    #1 chk("fl_stall_c1", 128'(o1_stall), 128'(1));
    @(posedge clk);
    #1 b.flush = 1'b1;
    #1 chk("fl_stall_c2", 128'(o1_stall), 128'(1));
    @(posedge clk);
    #1 b.valid = 1'b0;
    b.flush = 1'b0;
    #1 chk("fl_stall_after", 128'(o1_stall), 128'(0));
    v = mk(1, 1, 0, 3'b010, 32'h40, 32'h0, 5'd4);          issue1(v, 32'h13572468, 0, 1, seq);
    v = mk(1, 0, 0, 3'b000, 32'h77, 32'h0, 5'd9);          issue1(v, 32'h0, 0, 1, seq);
    chk("alu_no_stall", 128'(seq), 128'(8'h00));

    // Reset while a store waits: outputs clear at once, memory untouched
    b = mk(0, 0, 1, 3'b010, 32'h40, 32'h99999999, 5'd0);
    #1 chk("rst_stall_pre", 128'(o1_stall), 128'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_mid_wait", 128'({o1_stall, o1_valid, o1_rw, o1_fault, o1_rsrc, o1_rd, o1_alu, o1_rdata, o1_pc4}), 128'(0));
    b.valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    v = mk(1, 1, 0, 3'b010, 32'h40, 32'h0, 5'd5);          issue1(v, 32'h13572468, 0, 1, seq);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", 128'(q0.size()), 128'(0));
    chk("q1_drained", 128'(q1.size()), 128'(0));
    chk("dut0_never_stalls", 128'(stall0_seen), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
